// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mmio_pkg
//  Shared bus widths, GPIO register offsets and MMIO access attributes.
//  Rev    : 1.0
// ============================================================================
package mmio_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    localparam logic [2:0] OFF_OUT      = 3'd0;
    localparam logic [2:0] OFF_DIR      = 3'd1;
    localparam logic [2:0] OFF_IN       = 3'd2;
    localparam logic [2:0] OFF_STAT     = 3'd3;
    localparam logic [2:0] OFF_EDGE_EN  = 3'd4;
    localparam logic [2:0] OFF_EDGE_POL = 3'd5;
    localparam logic [2:0] OFF_TOGGLE   = 3'd6;
    localparam logic [2:0] OFF_ID       = 3'd7;

    localparam logic [1:0] ACC_RW  = 2'd0;
    localparam logic [1:0] ACC_RO  = 2'd1;
    localparam logic [1:0] ACC_W1C = 2'd2;
    localparam logic [1:0] ACC_WO  = 2'd3;

    function automatic logic [1:0] gpio_access(input logic [2:0] off);
        case (off)
            OFF_IN, OFF_ID: gpio_access = ACC_RO;
            OFF_STAT:       gpio_access = ACC_W1C;
            OFF_TOGGLE:     gpio_access = ACC_WO;
            default:        gpio_access = ACC_RW;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module : sync_2ff
//  Two-flop synchroniser for asynchronous inputs, cleared by reset.
//  Rev    : 1.0
// ============================================================================
module sync_2ff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule
`default_nettype wire

// File: rtl/mmio_gpio_port.sv
`default_nettype none
// ============================================================================
//  Module : mmio_gpio_port
//  Memory-mapped GPIO target: 8-byte register window, edge-detect IRQ.
//  Rev    : 1.0
// ============================================================================
module mmio_gpio_port
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter logic [7:0]  ID_VALUE  = 8'hA1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic [DATA_W-1:0] io_oe,
    output logic              irq
);

    localparam logic [ADDR_W-4:0] c_win = BASE_ADDR[ADDR_W-1:3];

    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_dir;
    logic [DATA_W-1:0] r_stat;
    logic [DATA_W-1:0] r_en;
    logic [DATA_W-1:0] r_pol;
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_hit;
    logic [2:0]        w_off;
    logic              w_rd;
    logic              w_wr;
    logic [DATA_W-1:0] w_sync;
    logic [DATA_W-1:0] w_rise;
    logic [DATA_W-1:0] w_fall;
    logic [DATA_W-1:0] w_ev;
    logic [DATA_W-1:0] w_w1c;
    logic [DATA_W-1:0] w_rmux;

    assign w_hit = (address[ADDR_W-1:3] == c_win);
    assign w_off = address[2:0];
    assign w_rd  = mem_read  & w_hit;
    assign w_wr  = mem_write & w_hit & (gpio_access(w_off) != ACC_RO);

    sync_2ff #(.W(DATA_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (io_in),
        .q     (w_sync)
    );

    // Per-bit polarity select; only fresh edges count, so EN/POL changes
    // never raise status for history that predates them.
    assign w_rise = w_sync & ~r_prev;
    assign w_fall = ~w_sync & r_prev;
    assign w_ev   = r_en & ((r_pol & w_fall) | (~r_pol & w_rise));
    assign w_w1c  = (w_wr && (w_off == OFF_STAT)) ? wdata : '0;

    always_comb begin
        w_rmux = '0;
        case (w_off)
            OFF_OUT:      w_rmux = r_out;
            OFF_DIR:      w_rmux = r_dir;
            OFF_IN:       w_rmux = w_sync;
            OFF_STAT:     w_rmux = r_stat;
            OFF_EDGE_EN:  w_rmux = r_en;
            OFF_EDGE_POL: w_rmux = r_pol;
            OFF_TOGGLE:   w_rmux = '0;
            OFF_ID:       w_rmux = ID_VALUE;
            default:      w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out    <= '0;
            r_dir    <= '0;
            r_stat   <= '0;
            r_en     <= '0;
            r_pol    <= '0;
            r_prev   <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_prev   <= w_sync;
            // Set wins over a coincident write-1-to-clear.
            r_stat   <= (r_stat & ~w_w1c) | w_ev;
            r_rvalid <= w_rd;
            // Read mux sees pre-write values, so a combined read+write returns old data.
            if (w_rd) begin
                r_rdata <= w_rmux;
            end
            if (w_wr) begin
                case (w_off)
                    OFF_OUT:      r_out <= wdata;
                    OFF_DIR:      r_dir <= wdata;
                    OFF_EDGE_EN:  r_en  <= wdata;
                    OFF_EDGE_POL: r_pol <= wdata;
                    OFF_TOGGLE:   r_out <= r_out ^ wdata;
                    default:      ;
                endcase
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign io_out = r_out;
    assign io_oe  = r_dir;
    assign irq    = |r_stat;

endmodule
`default_nettype wire

// File: tb/tb_mmio_gpio_port.sv
`default_nettype none
// ============================================================================
//  Module : tb_mmio_gpio_port
//  Directed bench for mmio_gpio_port with a per-cycle reference model.
//  Rev    : 1.0
// ============================================================================
module tb_mmio_gpio_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [7:0]  io_in = 8'h00;
    logic [7:0]  io_out;
    logic [7:0]  io_oe;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic run_cmp = 1'b0;

    mmio_gpio_port #(.BASE_ADDR(16'hFF00), .ID_VALUE(8'hA1)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_reg [8];      // architectural registers by offset
    logic [7:0] m_pin [3];      // pin samples: [0] newest edge, [2] oldest
    logic [7:0] m_rdata;
    logic       m_rvalid;

    function automatic logic in_window(input logic [15:0] a);
        return (a >= 16'hFF00) && (a <= 16'hFF07);
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] off);
        case (off)
            3'd2:    return m_pin[1];
            3'd6:    return 8'h00;
            3'd7:    return 8'hA1;
            default: return m_reg[off];
        endcase
    endfunction

    function automatic logic [7:0] model_stat(input logic [7:0] clr);
        logic [7:0] s;
        s = m_reg[3];
        for (int b = 0; b < 8; b++) begin
            logic now_v, old_v, hit;
            now_v = m_pin[1][b];
            old_v = m_pin[2][b];
            hit = m_reg[4][b] && (m_reg[5][b] ? (old_v && !now_v) : (!old_v && now_v));
            if (hit) s[b] = 1'b1;
            else if (clr[b]) s[b] = 1'b0;
        end
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_reg[i] <= 8'h00;
            for (int i = 0; i < 3; i++) m_pin[i] <= 8'h00;
            m_rdata  <= 8'h00;
            m_rvalid <= 1'b0;
        end else begin
            m_pin[0] <= io_in;
            m_pin[1] <= m_pin[0];
            m_pin[2] <= m_pin[1];
            m_rvalid <= mem_read && in_window(address);
            if (mem_read && in_window(address)) m_rdata <= model_read(address[2:0]);
            m_reg[3] <= model_stat((mem_write && in_window(address) && address[2:0] == 3'd3) ? wdata : 8'h00);
            if (mem_write && in_window(address)) begin
                case (address[2:0])
                    3'd0, 3'd1, 3'd4, 3'd5: m_reg[address[2:0]] <= wdata;
                    3'd6:    m_reg[0] <= m_reg[0] ^ wdata;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            check("model rdata",  rdata,         m_rdata);
            check("model rvalid", {7'd0, rvalid}, {7'd0, m_rvalid});
            check("model io_out", io_out,        m_reg[0]);
            check("model io_oe",  io_oe,         m_reg[1]);
            check("model irq",    {7'd0, irq},    {7'd0, |m_reg[3]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
        @(negedge clk);
        address   = a;
        wdata     = d;
        mem_read  = rd;
        mem_write = wr;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, d, 1'b0, 1'b1);
    endtask

    task automatic rd_expect(input string name, input logic [15:0] a, input logic [7:0] exp);
        bus(a, 8'h00, 1'b1, 1'b0);
        check({name, " rvalid"}, {7'd0, rvalid}, 8'h01);
        check(name, rdata, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cycles(3);
        reset = 1'b0;
        run_cmp = 1'b1;
        #1;
        check("reset rdata",  rdata,          8'h00);
        check("reset rvalid", {7'd0, rvalid}, 8'h00);
        check("reset io_out", io_out,         8'h00);
        check("reset io_oe",  io_oe,          8'h00);
        check("reset irq",    {7'd0, irq},    8'h00);

        // 1: ID read, rvalid is a single-cycle pulse
        rd_expect("id", 16'hFF07, 8'hA1);
        cycles(1);
        check("rvalid drops", {7'd0, rvalid}, 8'h00);

        // 2: direction, output, toggle
        wr(16'hFF01, 8'h0F);
        wr(16'hFF00, 8'h5A);
        wr(16'hFF06, 8'hFF);
        check("io_oe", io_oe, 8'h0F);
        check("io_out toggled", io_out, 8'hA5);
        rd_expect("out readback", 16'hFF00, 8'hA5);
        rd_expect("toggle reads 0", 16'hFF06, 8'h00);

        // 3: rising edge on bit 0
        wr(16'hFF04, 8'h01);
        wr(16'hFF05, 8'h00);
        io_in = 8'h01;
        cycles(2);
        check("irq not yet", {7'd0, irq}, 8'h00);
        cycles(1);
        check("irq rise", {7'd0, irq}, 8'h01);
        rd_expect("stat rise", 16'hFF03, 8'h01);
        rd_expect("stat read no clear", 16'hFF03, 8'h01);
        rd_expect("in pins", 16'hFF02, 8'h01);
        wr(16'hFF03, 8'h01);
        check("irq cleared", {7'd0, irq}, 8'h00);
        rd_expect("stat cleared", 16'hFF03, 8'h00);

        // 4: falling edge on bit 1, then set-wins against W1C
        wr(16'hFF04, 8'h02);
        wr(16'hFF05, 8'h02);
        io_in = 8'h03;
        cycles(4);
        rd_expect("no stat on rise w/ pol=1", 16'hFF03, 8'h00);
        io_in = 8'h01;
        cycles(3);
        check("irq fall", {7'd0, irq}, 8'h01);
        rd_expect("stat fall", 16'hFF03, 8'h02);
        wr(16'hFF03, 8'h02);
        check("irq clr2", {7'd0, irq}, 8'h00);
        io_in = 8'h03;
        cycles(4);
        io_in = 8'h01;
        cycles(2);
        wr(16'hFF03, 8'h02);
        check("set wins irq", {7'd0, irq}, 8'h01);
        rd_expect("set wins stat", 16'hFF03, 8'h02);

        // 5: outside the window
        wr(16'hFE00, 8'hFF);
        wr(16'hFF08, 8'hFF);
        check("miss no write", io_out, 8'hA5);
        bus(16'hFE07, 8'h00, 1'b1, 1'b0);
        check("miss FE07 rvalid", {7'd0, rvalid}, 8'h00);
        bus(16'hFF08, 8'h00, 1'b1, 1'b0);
        check("miss FF08 rvalid", {7'd0, rvalid}, 8'h00);
        wr(16'hFF07, 8'h00);
        rd_expect("id ro", 16'hFF07, 8'hA1);

        // 6: combined read+write, then reset mid-read
        wr(16'hFF00, 8'h11);
        bus(16'hFF00, 8'h22, 1'b1, 1'b1);
        check("rmw rvalid", {7'd0, rvalid}, 8'h01);
        check("rmw old data", rdata, 8'h11);
        check("rmw io_out", io_out, 8'h22);
        rd_expect("rmw new data", 16'hFF00, 8'h22);

        @(negedge clk);
        address  = 16'hFF07;
        mem_read = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("rst rdata",  rdata,          8'h00);
        check("rst rvalid", {7'd0, rvalid}, 8'h00);
        check("rst io_out", io_out,         8'h00);
        check("rst io_oe",  io_oe,          8'h00);
        check("rst irq",    {7'd0, irq},    8'h00);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cycles(1);
        check("post-rst rvalid", {7'd0, rvalid}, 8'h00);
        cycles(2);

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
